// File: rtl/speck_pkg.sv
// Shared SPECK128/128 constants, handshake FSM state type and rotate helpers.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package speck_pkg;

  localparam int WORD  = 64;
  localparam int ALPHA = 8;
  localparam int BETA  = 3;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } hs_state_t;

  // Rotate right by n (0..63); n == 0 yields x because the left shift by 64 is zero.
  function automatic logic [63:0] ror64(input logic [63:0] x, input int unsigned n);
    ror64 = (x >> n) | (x << (64 - n));
  endfunction

  // Rotate left by n (0..63).
  function automatic logic [63:0] rol64(input logic [63:0] x, input int unsigned n);
    rol64 = (x << n) | (x >> (64 - n));
  endfunction

endpackage

// File: rtl/speck_hs_stage.sv
// Generic latch/compute/hold handshake stage; the datapath lives outside and sees o_lat_dat.
// Latency: start sampled at edge N -> o_res/o_finished valid after edge N+1.
// Backpressure: none; start is ignored while BUSY, re-accepted in IDLE or DONE.
module speck_hs_stage
  import speck_pkg::*;
#(
  parameter int IN_W  = 8,
  parameter int OUT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_start,
  input  logic [IN_W-1:0]  i_dat,
  output logic [IN_W-1:0]  o_lat_dat,
  input  logic [OUT_W-1:0] i_res,
  output logic [OUT_W-1:0] o_res,
  output logic             o_finished
);

  hs_state_t        r_state;
  logic [IN_W-1:0]  r_lat;
  logic [OUT_W-1:0] r_res;
  logic             r_fin;

  // Handshake FSM: latch operands on accept, capture the computed result one cycle later, hold it.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_lat   <= '0;
      r_res   <= '0;
      r_fin   <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE, ST_DONE: begin
          if (i_start) begin
            r_lat   <= i_dat;
            r_fin   <= 1'b0;
            r_state <= ST_BUSY;
          end
        end
        ST_BUSY: begin
          r_res   <= i_res;
          r_fin   <= 1'b1;
          r_state <= ST_DONE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign o_lat_dat  = r_lat;
  assign o_res      = r_res;
  assign o_finished = r_fin;

endmodule

// File: rtl/speck_round_encrypt.sv
// One SPECK128/128 round plus one key-schedule step, each behind its own start/finished handshake.
// Latency: start at edge N -> result and finished after edge N+1, held until next accept.
// Backpressure: none; start ignored in BUSY. Key schedule present only with SPECK_KEY_SCHEDULE_EN.
module speck_round_encrypt #(
  parameter int WORD  = 64,
  parameter int ALPHA = 8,
  parameter int BETA  = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rnd_start,
  input  logic [2*WORD-1:0] plaintext,
  input  logic [WORD-1:0]   subkey,
  output logic [2*WORD-1:0] ciphertext,
  output logic              rnd_finished,
  input  logic              ks_start,
  input  logic [2*WORD-1:0] key,
  input  logic [4:0]        ks_round,
  output logic [2*WORD-1:0] out_key,
  output logic              ks_finished
);

  import speck_pkg::*;

  // ---------------- round channel ----------------
  logic [3*WORD-1:0] w_rnd_in;
  logic [3*WORD-1:0] w_rnd_lat;
  logic [WORD-1:0]   w_rx;
  logic [WORD-1:0]   w_ry;
  logic [WORD-1:0]   w_rk;
  logic [WORD-1:0]   w_rx_new;
  logic [WORD-1:0]   w_ry_new;

  assign w_rnd_in = {plaintext, subkey};
  assign w_rx     = w_rnd_lat[3*WORD-1:2*WORD];
  assign w_ry     = w_rnd_lat[2*WORD-1:WORD];
  assign w_rk     = w_rnd_lat[WORD-1:0];

  // Addition wraps modulo 2^64: the carry out of bit 63 is simply dropped.
  assign w_rx_new = (ror64(w_rx, ALPHA) + w_ry) ^ w_rk;
  assign w_ry_new = rol64(w_ry, BETA) ^ w_rx_new;

  speck_hs_stage #(
    .IN_W  (3*WORD),
    .OUT_W (2*WORD)
  ) u_rnd_stage (
    .clk        (clk),
    .rst        (rst),
    .i_start    (rnd_start),
    .i_dat      (w_rnd_in),
    .o_lat_dat  (w_rnd_lat),
    .i_res      ({w_rx_new, w_ry_new}),
    .o_res      (ciphertext),
    .o_finished (rnd_finished)
  );

  // ---------------- key-schedule channel ----------------
`ifdef SPECK_KEY_SCHEDULE_EN
  logic [2*WORD+4:0] w_ks_in;
  logic [2*WORD+4:0] w_ks_lat;
  logic [WORD-1:0]   w_kk;
  logic [WORD-1:0]   w_kl;
  logic [4:0]        w_ki;
  logic [WORD-1:0]   w_kl_new;
  logic [WORD-1:0]   w_kk_new;

  assign w_ks_in = {key, ks_round};
  assign w_kk    = w_ks_lat[2*WORD+4:WORD+5];
  assign w_kl    = w_ks_lat[WORD+4:5];
  assign w_ki    = w_ks_lat[4:0];

  // Round index is XORed as given; values >= 31 are not flagged.
  assign w_kl_new = (w_kk + ror64(w_kl, ALPHA)) ^ {{(WORD-5){1'b0}}, w_ki};
  assign w_kk_new = rol64(w_kk, BETA) ^ w_kl_new;

  speck_hs_stage #(
    .IN_W  (2*WORD+5),
    .OUT_W (2*WORD)
  ) u_ks_stage (
    .clk        (clk),
    .rst        (rst),
    .i_start    (ks_start),
    .i_dat      (w_ks_in),
    .o_lat_dat  (w_ks_lat),
    .i_res      ({w_kk_new, w_kl_new}),
    .o_res      (out_key),
    .o_finished (ks_finished)
  );
`else
  // Channel absent: outputs tied low, request inputs deliberately left unconsumed.
  logic w_unused_ks;
  assign w_unused_ks = ^{ks_start, key, ks_round};
  assign out_key     = '0;
  assign ks_finished = 1'b0;
`endif

endmodule

// File: tb/tb_speck_round_encrypt.sv
// Directed-vector bench for speck_round_encrypt with hand-computed expected values.
module tb_speck_round_encrypt;

  logic         clk;
  logic         rst;
  logic         rnd_start;
  logic [127:0] plaintext;
  logic [63:0]  subkey;
  logic [127:0] ciphertext;
  logic         rnd_finished;
  logic         ks_start;
  logic [127:0] key;
  logic [4:0]   ks_round;
  logic [127:0] out_key;
  logic         ks_finished;

  int n_checks;
  int n_errors;

  speck_round_encrypt dut (
    .clk          (clk),
    .rst          (rst),
    .rnd_start    (rnd_start),
    .plaintext    (plaintext),
    .subkey       (subkey),
    .ciphertext   (ciphertext),
    .rnd_finished (rnd_finished),
    .ks_start     (ks_start),
    .key          (key),
    .ks_round     (ks_round),
    .out_key      (out_key),
    .ks_finished  (ks_finished)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Advance past one rising edge and settle.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One-cycle round request; checks finished drops on accept and result one edge later.
  task automatic run_round(input string tag, input logic [127:0] pt, input logic [63:0] sk,
                           input logic [127:0] exp);
    plaintext = pt;
    subkey    = sk;
    rnd_start = 1'b1;
    tick();
    rnd_start = 1'b0;
    chk({tag, "_busy_fin"}, {127'd0, rnd_finished}, 128'd0);
    tick();
    chk({tag, "_ct"}, ciphertext, exp);
    chk({tag, "_fin"}, {127'd0, rnd_finished}, 128'd1);
  endtask

`ifdef SPECK_KEY_SCHEDULE_EN
  task automatic run_ks(input string tag, input logic [127:0] k, input logic [4:0] i,
                        input logic [127:0] exp);
    key      = k;
    ks_round = i;
    ks_start = 1'b1;
    tick();
    ks_start = 1'b0;
    chk({tag, "_busy_fin"}, {127'd0, ks_finished}, 128'd0);
    tick();
    chk({tag, "_key"}, out_key, exp);
    chk({tag, "_fin"}, {127'd0, ks_finished}, 128'd1);
  endtask
`endif

  typedef struct {
    logic [127:0] pt;
    logic [63:0]  sk;
    logic [127:0] exp;
  } rvec_t;

  rvec_t rvecs[4];

  initial begin
    n_checks  = 0;
    n_errors  = 0;
    rst       = 1'b1;
    rnd_start = 1'b0;
    plaintext = '0;
    subkey    = '0;
    ks_start  = 1'b0;
    key       = '0;
    ks_round  = '0;

    rvecs[0] = '{{64'd0, 64'd1}, 64'd0, {64'd1, 64'd9}};
    rvecs[1] = '{{64'd0, 64'd1}, 64'hFFFF_FFFF_FFFF_FFFF,
                 {64'hFFFF_FFFF_FFFF_FFFE, 64'hFFFF_FFFF_FFFF_FFF6}};
    rvecs[2] = '{{64'h0FF, 64'd0}, 64'd0,
                 {64'hFF00_0000_0000_0000, 64'hFF00_0000_0000_0000}};
    rvecs[3] = '{{64'h100, 64'hFFFF_FFFF_FFFF_FFFF}, 64'd0,
                 {64'd0, 64'hFFFF_FFFF_FFFF_FFFF}};

    // Reset and idle
    tick();
    tick();
    rst = 1'b0;
    tick();
    tick();
    chk("rst_ct", ciphertext, 128'd0);
    chk("rst_rfin", {127'd0, rnd_finished}, 128'd0);
    chk("rst_okey", out_key, 128'd0);
    chk("rst_kfin", {127'd0, ks_finished}, 128'd0);

    // Zero round, result held while idle
    run_round("zero", 128'd0, 64'd0, 128'd0);
    tick();
    tick();
    tick();
    chk("zero_hold_ct", ciphertext, 128'd0);
    chk("zero_hold_fin", {127'd0, rnd_finished}, 128'd1);

    // Round vectors, including carry wrap; each start comes from DONE (back-to-back)
    for (int i = 0; i < 4; i++) begin
      run_round($sformatf("rvec%0d", i), rvecs[i].pt, rvecs[i].sk, rvecs[i].exp);
    end

    // Inputs changed right after the accepting edge must not affect the result
    plaintext = {64'd0, 64'd1};
    subkey    = 64'd0;
    rnd_start = 1'b1;
    tick();
    rnd_start = 1'b0;
    plaintext = 128'h1234_5678_9ABC_DEF0_0FED_CBA9_8765_4321;
    subkey    = 64'hDEAD_BEEF_CAFE_F00D;
    tick();
    chk("latch_ct", ciphertext, {64'd1, 64'd9});
    chk("latch_fin", {127'd0, rnd_finished}, 128'd1);

    // Start held in BUSY with new inputs is ignored
    plaintext = {64'h0FF, 64'd0};
    subkey    = 64'd0;
    rnd_start = 1'b1;
    tick();
    plaintext = {64'd0, 64'd1};
    subkey    = 64'hFFFF_FFFF_FFFF_FFFF;
    tick();
    rnd_start = 1'b0;
    chk("busy_ign_ct", ciphertext, {64'hFF00_0000_0000_0000, 64'hFF00_0000_0000_0000});
    chk("busy_ign_fin", {127'd0, rnd_finished}, 128'd1);
    tick();
    chk("busy_ign_hold", ciphertext, {64'hFF00_0000_0000_0000, 64'hFF00_0000_0000_0000});

    // Reset asserted while BUSY aborts and clears
    plaintext = {64'd0, 64'd1};
    subkey    = 64'd0;
    rnd_start = 1'b1;
    tick();
    rnd_start = 1'b0;
    rst       = 1'b1;
    tick();
    rst = 1'b0;
    chk("rst_busy_ct", ciphertext, 128'd0);
    chk("rst_busy_fin", {127'd0, rnd_finished}, 128'd0);
    tick();
    chk("rst_busy_idle_fin", {127'd0, rnd_finished}, 128'd0);

`ifdef SPECK_KEY_SCHEDULE_EN
    run_ks("ks_a", {64'd1, 64'h100}, 5'd0, {64'hA, 64'h2});
    run_ks("ks_b", 128'd0, 5'd5, {64'd5, 64'd5});
    run_ks("ks_i31", 128'd0, 5'd31, {64'h1F, 64'h1F});

    // Both channels started on the same edge
    plaintext = {64'd0, 64'd1};
    subkey    = 64'd0;
    key       = {64'd1, 64'h100};
    ks_round  = 5'd0;
    rnd_start = 1'b1;
    ks_start  = 1'b1;
    tick();
    rnd_start = 1'b0;
    ks_start  = 1'b0;
    tick();
    chk("both_ct", ciphertext, {64'd1, 64'd9});
    chk("both_key", out_key, {64'hA, 64'h2});
    chk("both_fin", {126'd0, rnd_finished, ks_finished}, 128'd3);
`else
    // Channel absent: requests do nothing, round channel runs normally alongside
    plaintext = {64'd0, 64'd1};
    subkey    = 64'd0;
    key       = {64'd1, 64'h100};
    ks_round  = 5'd0;
    rnd_start = 1'b1;
    ks_start  = 1'b1;
    tick();
    rnd_start = 1'b0;
    ks_start  = 1'b0;
    tick();
    chk("both_ct", ciphertext, {64'd1, 64'd9});
    chk("both_rfin", {127'd0, rnd_finished}, 128'd1);
    chk("nks_key", out_key, 128'd0);
    chk("nks_fin", {127'd0, ks_finished}, 128'd0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
